// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   pipe_ctrl_state_t : sequencer FSM states
//   stage_ctrl_t      : enable/flush pair that drives one pipeline register
//   stage_ctrl()      : builds a stage_ctrl_t from its two bits
package pipeline_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } stage_ctrl_t;

    function automatic stage_ctrl_t stage_ctrl(input logic enable, input logic flush);
        stage_ctrl_t sc;
        sc.enable = enable;
        sc.flush  = flush;
        return sc;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   CLK   : system clock, rising edge
//   RST   : synchronous active-high reset, clears the count
//   inc   : add one this cycle unless already at all-ones
//   count : registered count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Inputs : CLK, RST (sync, active-high), ihit, dhit, dmemREN_EX_MEM,
//          dmemWEN_EX_MEM, memREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
//          pc_redirect_EX, halt_EX_MEM
// Outputs: pc_enable, enable_/flush_ for IF_ID, ID_EX, EX_MEM, MEM_WB
//          (combinational from state + inputs), halted (sticky, registered),
//          stall_count / flush_count (saturating, registered).
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_EX_MEM,
    input  logic             dmemWEN_EX_MEM,
    input  logic             memREN_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             pc_redirect_EX,
    input  logic             halt_EX_MEM,
    output logic             pc_enable,
    output logic             enable_IF_ID,
    output logic             enable_ID_EX,
    output logic             enable_EX_MEM,
    output logic             enable_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    pipe_ctrl_state_t state_r;
    pipe_ctrl_state_t next_state_s;
    logic             halted_r;

    logic        mem_req_s;
    logic        load_use_s;
    logic        stall_inc_s;
    logic        flush_inc_s;

    // Outcome of the normal-flow rules (redirect, load-use, imiss, advance).
    logic        run_pc_s;
    stage_ctrl_t run_if_id_s;
    stage_ctrl_t run_id_ex_s;
    stage_ctrl_t run_ex_mem_s;
    stage_ctrl_t run_mem_wb_s;

    // Final per-cycle control.
    logic        pc_s;
    stage_ctrl_t if_id_s;
    stage_ctrl_t id_ex_s;
    stage_ctrl_t ex_mem_s;
    stage_ctrl_t mem_wb_s;

    assign mem_req_s  = dmemREN_EX_MEM | dmemWEN_EX_MEM;
    // $zero is never a real dependency, so a load into r0 never stalls.
    assign load_use_s = memREN_ID_EX & (Rt_ID_EX != 5'd0) &
                        ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    // Normal-flow rules; also reused for the cycle that ends a memory wait.
    always_comb begin
        run_pc_s     = 1'b1;
        run_if_id_s  = stage_ctrl(1'b1, 1'b0);
        run_id_ex_s  = stage_ctrl(1'b1, 1'b0);
        run_ex_mem_s = stage_ctrl(1'b1, 1'b0);
        run_mem_wb_s = stage_ctrl(1'b1, 1'b0);
        if (pc_redirect_EX) begin
            // Wrong-path instructions in IF and ID are squashed; PC loads the target.
            run_if_id_s = stage_ctrl(1'b1, 1'b1);
            run_id_ex_s = stage_ctrl(1'b1, 1'b1);
        end else if (load_use_s) begin
            // Hold PC and IF_ID, inject a bubble into EX.
            run_pc_s    = 1'b0;
            run_if_id_s = stage_ctrl(1'b0, 1'b0);
            run_id_ex_s = stage_ctrl(1'b1, 1'b1);
        end else if (!ihit) begin
            // Fetch not ready: hold PC, bubble into ID, let older work drain.
            run_pc_s    = 1'b0;
            run_if_id_s = stage_ctrl(1'b1, 1'b1);
        end else begin
            run_pc_s = 1'b1;
        end
    end

    // Top-level control selection and next-state decode.
    always_comb begin
        pc_s         = 1'b0;
        if_id_s      = stage_ctrl(1'b0, 1'b0);
        id_ex_s      = stage_ctrl(1'b0, 1'b0);
        ex_mem_s     = stage_ctrl(1'b0, 1'b0);
        mem_wb_s     = stage_ctrl(1'b0, 1'b0);
        next_state_s = state_r;
        if (RST) begin
            if_id_s      = stage_ctrl(1'b0, 1'b1);
            id_ex_s      = stage_ctrl(1'b0, 1'b1);
            ex_mem_s     = stage_ctrl(1'b0, 1'b1);
            mem_wb_s     = stage_ctrl(1'b0, 1'b1);
            next_state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (halt_EX_MEM) begin
                        // Let the instructions ahead of halt retire, squash the rest.
                        if_id_s      = stage_ctrl(1'b0, 1'b1);
                        id_ex_s      = stage_ctrl(1'b0, 1'b1);
                        ex_mem_s     = stage_ctrl(1'b0, 1'b1);
                        mem_wb_s     = stage_ctrl(1'b1, 1'b0);
                        next_state_s = DRAIN;
                    end else if (mem_req_s && !dhit) begin
                        next_state_s = MEM_WAIT;
                    end else begin
                        pc_s     = run_pc_s;
                        if_id_s  = run_if_id_s;
                        id_ex_s  = run_id_ex_s;
                        ex_mem_s = run_ex_mem_s;
                        mem_wb_s = run_mem_wb_s;
                    end
                end
                MEM_WAIT: begin
                    // Dcache owns the arbiter: everything freezes until dhit.
                    if (dhit) begin
                        pc_s         = run_pc_s;
                        if_id_s      = run_if_id_s;
                        id_ex_s      = run_id_ex_s;
                        ex_mem_s     = run_ex_mem_s;
                        mem_wb_s     = run_mem_wb_s;
                        next_state_s = RUN;
                    end else begin
                        next_state_s = MEM_WAIT;
                    end
                end
                DRAIN: begin
                    if_id_s      = stage_ctrl(1'b0, 1'b1);
                    id_ex_s      = stage_ctrl(1'b0, 1'b1);
                    ex_mem_s     = stage_ctrl(1'b0, 1'b1);
                    mem_wb_s     = stage_ctrl(1'b1, 1'b0);
                    next_state_s = HALTED;
                end
                HALTED: begin
                    next_state_s = HALTED;
                end
                default: begin
                    next_state_s = RUN;
                end
            endcase
        end
    end

    // FSM state and sticky halted flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            halted_r <= halted_r | (state_r == DRAIN);
        end
    end

    assign stall_inc_s = ~pc_s & (state_r != HALTED) & ~RST;
    assign flush_inc_s = (if_id_s.flush | id_ex_s.flush | ex_mem_s.flush | mem_wb_s.flush) & ~RST;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc_s),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_inc_s),
        .count (flush_count)
    );

    assign pc_enable     = pc_s;
    assign enable_IF_ID  = if_id_s.enable;
    assign enable_ID_EX  = id_ex_s.enable;
    assign enable_EX_MEM = ex_mem_s.enable;
    assign enable_MEM_WB = mem_wb_s.enable;
    assign flush_IF_ID   = if_id_s.flush;
    assign flush_ID_EX   = id_ex_s.flush;
    assign flush_EX_MEM  = ex_mem_s.flush;
    assign flush_MEM_WB  = mem_wb_s.flush;
    assign halted        = halted_r;

endmodule
